// File: rtl/adc_frame_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_frame_collector                                          |
// | Description : Issues periodic SYNC requests to the ADC wrapper, gathers    |
// |               the returned per-channel samples into one N_CH-wide frame,   |
// |               checks channel order and collection time, and hands frames   |
// |               downstream on a valid/ready interface.                       |
// |               Optional feature macro: ADC_FRAME_AVG_EN (averages           |
// |               2**AVG_LOG2 complete frames before presenting one).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adc_frame_collector #(
    parameter int DW       = 16,
    parameter int N_CH     = 6,
    parameter int CH_W     = 3,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 1024,
    parameter int AVG_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 enable_i,
    input  logic [PERIOD_W-1:0]  period_i,
    input  logic                 op_mode_i,
    output logic                 sync_o,
    input  logic [DW-1:0]        smp_data_i,
    input  logic [CH_W-1:0]      smp_ch_i,
    input  logic                 smp_rd_en_i,
    output logic [N_CH*DW-1:0]   frm_data_o,
    output logic [15:0]          frm_seq_o,
    output logic                 frm_valid_o,
    input  logic                 frm_ready_i,
    output logic                 err_order_o,
    output logic                 err_tmo_o,
    output logic                 overrun_o
);

    localparam int c_FW    = N_CH * DW;
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_TICK = 2'd1;
    localparam logic [1:0] c_COLLECT   = 2'd2;

    // Control state
    logic [1:0]          state_q,   state_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [c_TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CH_W-1:0]     exp_ch_q,  exp_ch_d;

    // Registered pulse outputs
    logic sync_q,      sync_d;
    logic err_order_q, err_order_d;
    logic err_tmo_q,   err_tmo_d;
    logic overrun_q,   overrun_d;

    // Output frame register
    logic [c_FW-1:0] frm_data_q;
    logic [15:0]     frm_seq_q;
    logic [15:0]     seq_cnt_q;
    logic            frm_valid_q;

    // Combinational helpers
    logic                w_run;
    logic [PERIOD_W-1:0] w_per_last;
    logic                w_tick;
    logic                w_in_collect;
    logic                w_smp_hit;
    logic                w_smp_bad;
    logic                w_last_ch;
    logic                w_complete;
    logic                w_order_err;
    logic                w_timeout;
    logic                w_tick_ovr;
    logic [c_FW-1:0]     w_frame;
    logic                w_emit;
    logic [c_FW-1:0]     w_emit_data;
    logic                w_accept;
    logic                w_load;
    logic                w_drop;

    assign w_run        = enable_i & op_mode_i;
    // Periods below 2 behave as 2 so a tick never lands on back-to-back cycles
    assign w_per_last   = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : (period_i - PERIOD_W'(1));
    assign w_tick       = (state_q != c_IDLE) && (per_cnt_q == w_per_last);
    assign w_in_collect = (state_q == c_COLLECT);

    assign w_smp_hit    = w_run && w_in_collect && smp_rd_en_i && (smp_ch_i == exp_ch_q);
    assign w_smp_bad    = w_run && w_in_collect && smp_rd_en_i && (smp_ch_i != exp_ch_q);
    assign w_last_ch    = (exp_ch_q == CH_W'(N_CH - 1));
    assign w_complete   = w_smp_hit && w_last_ch;
    assign w_order_err  = w_smp_bad;
    // A sample arriving on the final allowed cycle still counts; only an
    // unfinished, error-free collection times out
    assign w_timeout    = w_run && w_in_collect && (tmo_cnt_q == c_TMO_W'(TIMEOUT - 1))
                          && !w_complete && !w_order_err;
    // A tick that coincides with completion is absorbed silently
    assign w_tick_ovr   = w_run && w_in_collect && w_tick && !w_complete;

    // Frame buffer: channels below the last are held in registers, the last
    // channel is taken straight from the sample bus on the completing cycle
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        if (k < N_CH - 1) begin : g_store
            logic [DW-1:0] smp_q;

            // Capture the sample for this channel when it arrives in order
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    smp_q <= '0;
                end else if (w_smp_hit && (exp_ch_q == CH_W'(k))) begin
                    smp_q <= smp_data_i;
                end
            end

            assign w_frame[k*DW +: DW] = smp_q;
        end else begin : g_last
            assign w_frame[k*DW +: DW] = smp_data_i;
        end
    end

`ifdef ADC_FRAME_AVG_EN
    localparam int c_AW = DW + AVG_LOG2;
    localparam int c_CW = AVG_LOG2 + 1;

    logic [c_CW-1:0] avg_cnt_q, avg_cnt_d;
    logic            w_abort;
    logic            w_avg_last;

    // Any discarded collection or leaving acquisition restarts the average
    assign w_abort    = !w_run || w_order_err || w_timeout;
    assign w_avg_last = (avg_cnt_q == c_CW'((1 << AVG_LOG2) - 1));
    assign w_emit     = w_complete && w_avg_last;

    // Count complete frames folded into the running sums
    always_comb begin
        avg_cnt_d = avg_cnt_q;
        if (w_abort) begin
            avg_cnt_d = '0;
        end else if (w_complete) begin
            avg_cnt_d = w_avg_last ? '0 : (avg_cnt_q + c_CW'(1));
        end
    end

    // Frame-count register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            avg_cnt_q <= '0;
        end else begin
            avg_cnt_q <= avg_cnt_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_acc
        logic [c_AW-1:0] acc_q, acc_d, w_sum;

        assign w_sum = acc_q + c_AW'(w_frame[k*DW +: DW]);

        // Accumulate each complete frame, clear after the averaged frame leaves
        always_comb begin
            acc_d = acc_q;
            if (w_abort) begin
                acc_d = '0;
            end else if (w_complete) begin
                acc_d = w_avg_last ? '0 : w_sum;
            end
        end

        // Per-channel accumulator register
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        // Unsigned truncating divide by 2**AVG_LOG2
        assign w_emit_data[k*DW +: DW] = w_sum[AVG_LOG2 +: DW];
    end
`else
    logic w_unused_avg;

    assign w_emit       = w_complete;
    assign w_emit_data  = w_frame;
    assign w_unused_avg = (AVG_LOG2 > 0);
`endif

    assign w_accept = frm_valid_q & frm_ready_i;
    assign w_load   = w_emit && (!frm_valid_q || frm_ready_i);
    assign w_drop   = w_emit && !w_load;

    assign sync_d      = w_run && (state_q == c_WAIT_TICK) && w_tick;
    assign err_order_d = w_order_err;
    assign err_tmo_d   = w_timeout;
    assign overrun_d   = w_tick_ovr | w_drop;

    // Next-state logic for acquisition control
    always_comb begin
        state_d   = state_q;
        exp_ch_d  = exp_ch_q;
        tmo_cnt_d = tmo_cnt_q;
        if (!w_run) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE: begin
                    state_d = c_WAIT_TICK;
                end
                c_WAIT_TICK: begin
                    if (w_tick) begin
                        state_d   = c_COLLECT;
                        exp_ch_d  = '0;
                        tmo_cnt_d = '0;
                    end
                end
                c_COLLECT: begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                    if (w_smp_hit) begin
                        exp_ch_d = exp_ch_q + CH_W'(1);
                    end
                    if (w_complete || w_order_err || w_timeout) begin
                        state_d = c_WAIT_TICK;
                    end
                end
                default: begin
                    state_d = c_IDLE;
                end
            endcase
        end
    end

    // Period counter free-runs outside IDLE and restarts after each tick
    always_comb begin
        per_cnt_d = per_cnt_q + PERIOD_W'(1);
        if (!w_run || (state_q == c_IDLE) || w_tick) begin
            per_cnt_d = '0;
        end
    end

    // Control and pulse registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= c_IDLE;
            per_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            exp_ch_q    <= '0;
            sync_q      <= 1'b0;
            err_order_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            exp_ch_q    <= exp_ch_d;
            sync_q      <= sync_d;
            err_order_q <= err_order_d;
            err_tmo_q   <= err_tmo_d;
            overrun_q   <= overrun_d;
        end
    end

    // Output frame register: holds data and sequence steady while valid
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            frm_data_q  <= '0;
            frm_seq_q   <= '0;
            seq_cnt_q   <= '0;
            frm_valid_q <= 1'b0;
        end else if (w_load) begin
            frm_data_q  <= w_emit_data;
            frm_seq_q   <= seq_cnt_q;
            seq_cnt_q   <= seq_cnt_q + 16'd1;
            frm_valid_q <= 1'b1;
        end else if (w_accept) begin
            frm_valid_q <= 1'b0;
        end
    end

    assign sync_o      = sync_q;
    assign err_order_o = err_order_q;
    assign err_tmo_o   = err_tmo_q;
    assign overrun_o   = overrun_q;
    assign frm_data_o  = frm_data_q;
    assign frm_seq_o   = frm_seq_q;
    assign frm_valid_o = frm_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adc_frame_collector                                       |
// | Description : Directed bench for adc_frame_collector with a transaction-   |
// |               level reference model compared on every cycle.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adc_frame_collector;

    localparam int DW       = 16;
    localparam int N_CH     = 6;
    localparam int CH_W     = 3;
    localparam int PERIOD_W = 16;
    localparam int TIMEOUT  = 1024;
    localparam int AVG_LOG2 = 2;
    localparam int FW       = N_CH * DW;

    logic                clk         = 1'b0;
    logic                rst_l       = 1'b0;
    logic                enable_i    = 1'b0;
    logic [PERIOD_W-1:0] period_i    = 16'd100;
    logic                op_mode_i   = 1'b0;
    logic [DW-1:0]       smp_data_i  = '0;
    logic [CH_W-1:0]     smp_ch_i    = '0;
    logic                smp_rd_en_i = 1'b0;
    logic                frm_ready_i = 1'b1;
    logic                sync_o;
    logic [FW-1:0]       frm_data_o;
    logic [15:0]         frm_seq_o;
    logic                frm_valid_o;
    logic                err_order_o;
    logic                err_tmo_o;
    logic                overrun_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    adc_frame_collector #(
        .DW(DW), .N_CH(N_CH), .CH_W(CH_W), .PERIOD_W(PERIOD_W),
        .TIMEOUT(TIMEOUT), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .rst_l(rst_l), .enable_i(enable_i), .period_i(period_i),
        .op_mode_i(op_mode_i), .sync_o(sync_o), .smp_data_i(smp_data_i),
        .smp_ch_i(smp_ch_i), .smp_rd_en_i(smp_rd_en_i), .frm_data_o(frm_data_o),
        .frm_seq_o(frm_seq_o), .frm_valid_o(frm_valid_o), .frm_ready_i(frm_ready_i),
        .err_order_o(err_order_o), .err_tmo_o(err_tmo_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Tracks acquisition as "active / collecting" plus counters in plain ints;
    // expected outputs for the next cycle are computed at each clock edge.
    bit            m_active, m_coll;
    int            m_pos, m_age, m_next, m_nfr, m_seq_next;
    logic [DW-1:0] m_smp [N_CH];
    int            m_acc [N_CH];
    bit            m_valid;
    logic [FW-1:0] m_data;
    logic [15:0]   m_seq;
    bit            e_sync, e_ord, e_tmo, e_ovr;

    always @(posedge clk or negedge rst_l) begin
        bit run, was_coll, tick, done, emit, accept;
        int eff;
        logic [FW-1:0] f;
        if (!rst_l) begin
            m_active = 0; m_coll = 0; m_pos = 0; m_age = 0; m_next = 0; m_nfr = 0;
            m_seq_next = 0; m_valid = 0; m_data = '0; m_seq = '0;
            e_sync = 0; e_ord = 0; e_tmo = 0; e_ovr = 0;
            for (int k = 0; k < N_CH; k++) begin m_acc[k] = 0; m_smp[k] = '0; end
        end else begin
            e_sync = 0; e_ord = 0; e_tmo = 0; e_ovr = 0;
            run    = enable_i && op_mode_i;
            accept = m_valid && frm_ready_i;
            done = 0; emit = 0; f = '0;
            eff = (period_i < 2) ? 2 : int'(period_i);
            if (!run) begin
                m_active = 0; m_coll = 0; m_pos = 0; m_nfr = 0;
                for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
            end else if (!m_active) begin
                m_active = 1; m_pos = 0;
            end else begin
                tick     = (m_pos == eff - 1);
                m_pos    = tick ? 0 : m_pos + 1;
                was_coll = m_coll;
                if (m_coll && smp_rd_en_i) begin
                    if (int'(smp_ch_i) == m_next) begin
                        m_smp[m_next] = smp_data_i;
                        m_next++;
                        if (m_next == N_CH) begin done = 1; m_coll = 0; end
                    end else begin
                        e_ord = 1; m_coll = 0; m_nfr = 0;
                        for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
                    end
                end
                if (m_coll) begin
                    if (m_age + 1 == TIMEOUT) begin
                        e_tmo = 1; m_coll = 0; m_nfr = 0;
                        for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
                    end else begin
                        m_age++;
                    end
                end
                if (tick) begin
                    if (was_coll) begin
                        if (!done) e_ovr = 1;
                    end else begin
                        e_sync = 1; m_coll = 1; m_next = 0; m_age = 0;
                    end
                end
                if (done) begin
`ifdef ADC_FRAME_AVG_EN
                    for (int k = 0; k < N_CH; k++) m_acc[k] += int'(m_smp[k]);
                    m_nfr++;
                    if (m_nfr == (1 << AVG_LOG2)) begin
                        emit = 1;
                        for (int k = 0; k < N_CH; k++) begin
                            f[k*DW +: DW] = DW'(m_acc[k] >> AVG_LOG2);
                            m_acc[k] = 0;
                        end
                        m_nfr = 0;
                    end
`else
                    emit = 1;
                    for (int k = 0; k < N_CH; k++) f[k*DW +: DW] = m_smp[k];
`endif
                end
            end
            if (emit) begin
                if (!m_valid || accept) begin
                    m_data = f; m_seq = m_seq_next[15:0]; m_seq_next++; m_valid = 1;
                end else begin
                    e_ovr = 1;
                end
            end else if (accept) begin
                m_valid = 0;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        check("sync_o", FW'(sync_o), FW'(e_sync));
        check("err_order_o", FW'(err_order_o), FW'(e_ord));
        check("err_tmo_o", FW'(err_tmo_o), FW'(e_tmo));
        check("overrun_o", FW'(overrun_o), FW'(e_ovr));
        check("frm_valid_o", FW'(frm_valid_o), FW'(m_valid));
        if (m_valid) begin
            check("frm_data_o", frm_data_o, m_data);
            check("frm_seq_o", FW'(frm_seq_o), FW'(m_seq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_sync(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sync_o === 1'b1) begin at = cyc; break; end
        end
        if (at < 0) expired(name);
    endtask

    task automatic send(input int ch, input int data);
        smp_rd_en_i = 1'b1;
        smp_ch_i    = CH_W'(ch);
        smp_data_i  = DW'(data);
        @(negedge clk);
        smp_rd_en_i = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f);
        for (int k = 0; k < N_CH; k++) begin
            smp_rd_en_i = 1'b1;
            smp_ch_i    = CH_W'(k);
            smp_data_i  = f[k*DW +: DW];
            @(negedge clk);
        end
        smp_rd_en_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, t, c0;
        logic [FW-1:0] d;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_sync", FW'(sync_o), '0);
        check("rst_valid", FW'(frm_valid_o), '0);
        check("rst_data", frm_data_o, '0);
        check("rst_seq", FW'(frm_seq_o), '0);

        rst_l = 1'b1; period_i = 16'd100; frm_ready_i = 1'b1;
        c0 = cyc;
        enable_i = 1'b1; op_mode_i = 1'b1;

        // Normal frames, sync spacing
        wait_sync("t1_sync0", 150, s0);
        check("t1_first_sync_delay", FW'(s0 - c0), FW'(101));
        send_frame(96'h1005_1004_1003_1002_1001_1000);
`ifndef ADC_FRAME_AVG_EN
        check("t1_valid", FW'(frm_valid_o), FW'(1));
        check("t1_data", frm_data_o, 96'h1005_1004_1003_1002_1001_1000);
        check("t1_seq", FW'(frm_seq_o), FW'(0));
`endif
        wait_sync("t1_sync1", 150, s1);
        check("t1_sync_period", FW'(s1 - s0), FW'(100));
        send_frame(96'h2005_2004_2003_2002_2001_2000);
`ifndef ADC_FRAME_AVG_EN
        check("t1_seq1", FW'(frm_seq_o), FW'(1));
`endif

        // Channel order error, then restart at ch0 on the next tick
        wait_sync("t2_sync", 150, s0);
        send(0, 16'h3000);
        send(2, 16'h3002);
        check("t2_err_order", FW'(err_order_o), FW'(1));
        wait_sync("t2_sync_next", 150, s1);
        check("t2_restart_period", FW'(s1 - s0), FW'(100));
        send_frame(96'h4005_4004_4003_4002_4001_4000);
`ifndef ADC_FRAME_AVG_EN
        check("t2_seq2", FW'(frm_seq_o), FW'(2));
        check("t2_data", frm_data_o, 96'h4005_4004_4003_4002_4001_4000);
`endif

        // Timeout: only ch0..3 returned
        wait_sync("t3_sync", 150, s0);
        for (int k = 0; k < 4; k++) send(k, 16'h5000 + k);
        t = -1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (err_tmo_o === 1'b1) begin t = cyc; break; end
        end
        if (t < 0) expired("t3_err_tmo");
        else check("t3_tmo_delay", FW'(t - s0), FW'(TIMEOUT));
        check("t3_no_frame", FW'(frm_valid_o), FW'(0));

        // Backpressure: held frame, dropped second frame, then accept
        frm_ready_i = 1'b0;
        wait_sync("t4_sync0", 150, s0);
        send_frame(96'h6005_6004_6003_6002_6001_6000);
        wait_sync("t4_sync1", 150, s1);
        send_frame(96'h7005_7004_7003_7002_7001_7000);
`ifndef ADC_FRAME_AVG_EN
        check("t4_overrun", FW'(overrun_o), FW'(1));
        check("t4_held_seq", FW'(frm_seq_o), FW'(3));
        check("t4_held_data", frm_data_o, 96'h6005_6004_6003_6002_6001_6000);
`endif
        frm_ready_i = 1'b1;
        @(negedge clk);
        check("t4_accepted", FW'(frm_valid_o), FW'(0));
        wait_sync("t4_sync2", 150, s0);
        send_frame(96'h8005_8004_8003_8002_8001_8000);
`ifndef ADC_FRAME_AVG_EN
        check("t4_seq_next", FW'(frm_seq_o), FW'(4));
`endif

        // op_mode drop mid-frame: silent discard
        wait_sync("t5_sync", 150, s0);
        for (int k = 0; k < 3; k++) send(k, 16'h9000 + k);
        op_mode_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_err", FW'({err_order_o, err_tmo_o}), FW'(0));
        op_mode_i = 1'b1;
        wait_sync("t5_sync_after", 150, s0);
        send_frame(96'hA005_A004_A003_A002_A001_A000);
`ifndef ADC_FRAME_AVG_EN
        check("t5_seq", FW'(frm_seq_o), FW'(5));
`endif

        // Period below 2 behaves as 2
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        period_i = 16'd1;
        c0 = cyc;
        enable_i = 1'b1;
        wait_sync("t6_sync", 10, s0);
        check("t6_min_period", FW'(s0 - c0), FW'(3));
        send_frame(96'hB005_B004_B003_B002_B001_B000);
        repeat (4) @(negedge clk);
        enable_i = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-frame
        period_i = 16'd100;
        enable_i = 1'b1;
        wait_sync("t7_sync", 150, s0);
        send(0, 16'hC000);
        #2 rst_l = 1'b0;
        @(negedge clk);
        check("t7_rst_outputs", FW'({sync_o, frm_valid_o, err_order_o, err_tmo_o, overrun_o}), FW'(0));
        check("t7_rst_seq", FW'(frm_seq_o), FW'(0));
        check("t7_rst_data", frm_data_o, '0);
        rst_l = 1'b1;

`ifdef ADC_FRAME_AVG_EN
        // Four frames averaged: ch0 10,11,12,14 -> 11; ch1 20,20,20,21 -> 20
        for (int n = 0; n < 4; n++) begin
            d = '0;
            d[DW-1:0]    = (n == 3) ? 16'd14 : DW'(10 + n);
            d[2*DW-1:DW] = (n == 3) ? 16'd21 : 16'd20;
            wait_sync("t8_sync", 150, s0);
            send_frame(d);
        end
        d = frm_data_o;
        check("t8_avg_valid", FW'(frm_valid_o), FW'(1));
        check("t8_avg_ch0", FW'(d[DW-1:0]), FW'(11));
        check("t8_avg_ch1", FW'(d[2*DW-1:DW]), FW'(20));
`endif

        enable_i = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
